// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - recovers DrawX/DrawY, active video, frame pulses and lock status from VGA hs/vs
module vga_sync_receiver #(
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       pixel_en,
  input  logic       hs,
  input  logic       vs,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       active,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err
);

  localparam logic [9:0] HA     = 10'(H_ACTIVE);
  localparam logic [9:0] HSS    = 10'(H_SYNC_START);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] VA     = 10'(V_ACTIVE);
  localparam logic [9:0] VSS    = 10'(V_SYNC_START);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [3:0] LF     = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    UNSYNCED = 2'd0,
    ALIGN    = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic       hs_q, vs_q;
  logic       hs_fall, vs_fall;
  logic [9:0] hx_next, vy_next;
  logic [9:0] x_nx, y_nx;
  logic [3:0] good_frames, gf_nx, gf_inc;
  // seen_vs: a vs edge has opened the current counting window in ALIGN
  logic       seen_vs, seen_nx;
  // dirty: an hs error happened since the last vs edge
  logic       dirty, dirty_nx;
  logic       herr_nx, verr_nx;
  logic       active_nx, fs_nx;

  assign hs_fall = pixel_en & hs_q & ~hs;
  assign vs_fall = pixel_en & vs_q & ~vs;
  assign gf_inc  = good_frames + 4'd1;

  // Free-running prediction of where the next pixel should land
  always_comb begin
    hx_next = (DrawX == H_LAST) ? 10'd0 : DrawX + 10'd1;
    vy_next = DrawY;
    if (hx_next == 10'd0) begin
      vy_next = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
    end
  end

  // Sync tracking FSM: counter loads, edge checks, frame qualification and output decode
  always_comb begin
    state_nx  = state;
    gf_nx     = good_frames;
    seen_nx   = seen_vs;
    dirty_nx  = dirty;
    x_nx      = DrawX;
    y_nx      = DrawY;
    herr_nx   = 1'b0;
    verr_nx   = 1'b0;
    active_nx = active;
    fs_nx     = 1'b0;

    if (pixel_en) begin
      x_nx = hs_fall ? HSS : hx_next;
      y_nx = vs_fall ? VSS : vy_next;

      case (state)
        UNSYNCED: begin
          if (hs_fall) begin
            state_nx = ALIGN;
            gf_nx    = 4'd0;
            seen_nx  = 1'b0;
            dirty_nx = 1'b0;
          end else begin
            x_nx = 10'd0;
            y_nx = 10'd0;
          end
        end

        ALIGN: begin
          herr_nx = hs_fall && (hx_next != HSS);
          verr_nx = vs_fall && (vy_next != VSS);
          if (vs_fall) begin
            seen_nx  = 1'b1;
            dirty_nx = 1'b0;
            if (herr_nx || verr_nx || dirty || !seen_vs) begin
              gf_nx = 4'd0;
            end else if (gf_inc == LF) begin
              gf_nx    = 4'd0;
              state_nx = LOCKED;
            end else begin
              gf_nx = gf_inc;
            end
          end else if (herr_nx) begin
            gf_nx    = 4'd0;
            dirty_nx = 1'b1;
          end
        end

        LOCKED: begin
          herr_nx = hs_fall && (hx_next != HSS);
          verr_nx = vs_fall && (vy_next != VSS);
          if (herr_nx || verr_nx) begin
            // An error on a vs edge closes that frame, so the next window starts clean
            state_nx = ALIGN;
            gf_nx    = 4'd0;
            seen_nx  = 1'b1;
            dirty_nx = herr_nx && !vs_fall;
          end
        end

        default: begin
          state_nx = UNSYNCED;
        end
      endcase

      active_nx = (state_nx == LOCKED) && (x_nx < HA) && (y_nx < VA);
      fs_nx     = (state_nx == LOCKED) && (x_nx == 10'd0) && (y_nx == 10'd0);
    end
  end

  // State, sync samples and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= UNSYNCED;
      good_frames <= 4'd0;
      seen_vs     <= 1'b0;
      dirty       <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
    end else begin
      state       <= state_nx;
      good_frames <= gf_nx;
      seen_vs     <= seen_nx;
      dirty       <= dirty_nx;
      if (pixel_en) begin
        hs_q <= hs;
        vs_q <= vs;
      end
      DrawX       <= x_nx;
      DrawY       <= y_nx;
      active      <= active_nx;
      frame_start <= fs_nx;
      locked      <= (state_nx == LOCKED);
      h_err       <= herr_nx;
      v_err       <= verr_nx;
    end
  end

endmodule
